wish_pack_flex: RTL and testbench

- Wishbone pipelined-mode packer.
- Gathers up to NUM_PACK source words of DATA_WIDTH bits into one destination word.
- Supports early end-of-frame flush, with a per-lane valid mask on the destination.
- A two-deep buffer (accumulator plus output register) lets the source keep streaming while the destination stalls.
- Sits between narrow stream producers (UART, ADC front ends) and wide bus consumers/FIFOs.

---
 rtl/wish_pack_flex_pkg.sv | 13 +
 rtl/wish_pack_lane_buf.sv | 91 +++++++++
 rtl/wish_pack_flex.sv | 83 ++++++++
 tb/tb_wish_pack_flex.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wish_pack_flex_pkg.sv
// Shared helpers for the Wishbone packer: lane counter width and lane placement.
package wish_pack_flex_pkg;

    function automatic int cnt_width(input int num_pack);
        return $clog2(num_pack + 1);
    endfunction

    // First word of a pack lands in lane 0 for little endian, top lane otherwise.
    function automatic int lane_idx(input int cnt, input int num_pack, input bit little_endian);
        return little_endian ? cnt : num_pack - 1 - cnt;
    endfunction

endpackage

// File: rtl/wish_pack_lane_buf.sv
// Accumulator for the packer: gathers source words into lanes and holds one
// completed pack while the output register is busy.
module wish_pack_lane_buf
    import wish_pack_flex_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           accept,
    input  logic                           out_free,
    input  logic [DATA_WIDTH-1:0]          s_dat,
    input  logic [TGC_WIDTH-1:0]           s_tgc,
    input  logic                           s_last,
    output logic                           acc_full,
    output logic                           pack_valid,
    output logic [DATA_WIDTH*NUM_PACK-1:0] pack_dat,
    output logic [NUM_PACK-1:0]            pack_sel,
    output logic [TGC_WIDTH-1:0]           pack_tgc,
    output logic                           pack_last
);

    localparam int CNT_W = cnt_width(NUM_PACK);
    localparam int PW    = DATA_WIDTH * NUM_PACK;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PACK - 1);

    logic [PW-1:0]        acc_dat, base_dat, wr_dat;
    logic [NUM_PACK-1:0]  acc_sel, base_sel, wr_sel;
    logic [TGC_WIDTH-1:0] acc_tgc, base_tgc, wr_tgc;
    logic                 acc_last;
    logic [CNT_W-1:0]     cnt, base_cnt;
    logic                 word_done;

    // A word accepted while a pack is pending always starts a fresh pack.
    always_comb begin
        base_dat = acc_full ? '0 : acc_dat;
        base_sel = acc_full ? '0 : acc_sel;
        base_tgc = acc_full ? '0 : acc_tgc;
        base_cnt = acc_full ? '0 : cnt;
        wr_dat   = base_dat;
        wr_sel   = base_sel;
        wr_tgc   = base_tgc;
        if (accept) begin
            wr_tgc = base_tgc | s_tgc;
            for (int i = 0; i < NUM_PACK; i++) begin
                if (i == lane_idx(int'(base_cnt), NUM_PACK, LITTLE_ENDIAN != 0)) begin
                    wr_dat[i*DATA_WIDTH +: DATA_WIDTH] = s_dat;
                    wr_sel[i] = 1'b1;
                end
            end
        end
        word_done = accept && ((base_cnt == LAST_CNT) || s_last);
    end

    assign pack_valid = acc_full | word_done;
    assign pack_dat   = acc_full ? acc_dat  : wr_dat;
    assign pack_sel   = acc_full ? acc_sel  : wr_sel;
    assign pack_tgc   = acc_full ? acc_tgc  : wr_tgc;
    assign pack_last  = acc_full ? acc_last : s_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_dat  <= '0;
            acc_sel  <= '0;
            acc_tgc  <= '0;
            acc_last <= 1'b0;
            acc_full <= 1'b0;
            cnt      <= '0;
        end else if (acc_full && !out_free) begin
            acc_full <= 1'b1;
        end else if (word_done && !acc_full && out_free) begin
            acc_dat  <= '0;
            acc_sel  <= '0;
            acc_tgc  <= '0;
            acc_last <= 1'b0;
            acc_full <= 1'b0;
            cnt      <= '0;
        end else begin
            acc_dat  <= wr_dat;
            acc_sel  <= wr_sel;
            acc_tgc  <= wr_tgc;
            acc_last <= word_done & s_last;
            acc_full <= word_done;
            cnt      <= word_done ? '0 : (accept ? base_cnt + CNT_W'(1) : base_cnt);
        end
    end

endmodule

// File: rtl/wish_pack_flex.sv
// Wishbone pipelined packer: gathers narrow source words into one wide
// destination word with lane mask, tag OR and end-of-frame flush.
module wish_pack_flex
    import wish_pack_flex_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PACK      = 4,
    parameter int TGC_WIDTH     = 2,
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    input  logic [DATA_WIDTH-1:0]          s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    input  logic                           s_last_i,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    input  logic                           d_ack_i,
    output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
    output logic [NUM_PACK-1:0]            d_sel_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o,
    output logic                           d_last_o
);

    logic                           accept;
    logic                           out_free;
    logic                           acc_full;
    logic                           pack_valid;
    logic [DATA_WIDTH*NUM_PACK-1:0] pack_dat;
    logic [NUM_PACK-1:0]            pack_sel;
    logic [TGC_WIDTH-1:0]           pack_tgc;
    logic                           pack_last;

    assign out_free  = !d_stb_o | d_ack_i;
    assign s_stall_o = acc_full & !out_free & !rst_i;
    assign accept    = s_stb_i & s_cyc_i & !s_stall_o & !rst_i;
    assign s_ack_o   = accept;

    wish_pack_lane_buf #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_PACK     (NUM_PACK),
        .TGC_WIDTH    (TGC_WIDTH),
        .LITTLE_ENDIAN(LITTLE_ENDIAN)
    ) u_lane_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .accept    (accept),
        .out_free  (out_free),
        .s_dat     (s_dat_i),
        .s_tgc     (s_tgc_i),
        .s_last    (s_last_i),
        .acc_full  (acc_full),
        .pack_valid(pack_valid),
        .pack_dat  (pack_dat),
        .pack_sel  (pack_sel),
        .pack_tgc  (pack_tgc),
        .pack_last (pack_last)
    );

    // An ack with a pack ready reloads in place, keeping the strobe high.
    always_ff @(posedge clk_i) begin
        if (rst_i || (out_free && !pack_valid)) begin
            d_stb_o  <= 1'b0;
            d_cyc_o  <= 1'b0;
            d_dat_o  <= '0;
            d_sel_o  <= '0;
            d_tgc_o  <= '0;
            d_last_o <= 1'b0;
        end else if (out_free) begin
            d_stb_o  <= 1'b1;
            d_cyc_o  <= 1'b1;
            d_dat_o  <= pack_dat;
            d_sel_o  <= pack_sel;
            d_tgc_o  <= pack_tgc;
            d_last_o <= pack_last;
        end
    end

endmodule

// File: tb/tb_wish_pack_flex.sv
// Directed bench for wish_pack_flex: little/big endian packing, frame flush,
// destination backpressure, streaming, NUM_PACK=1 and mid-pack reset.
module tb_wish_pack_flex;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_stb, s_cyc, s_last, d_ack;
    logic [7:0] s_dat;
    logic [1:0] s_tgc;

    logic        le_s_ack, le_s_stall, le_d_stb, le_d_cyc, le_d_last;
    logic [31:0] le_d_dat;
    logic [3:0]  le_d_sel;
    logic [1:0]  le_d_tgc;

    logic        be_s_ack, be_s_stall, be_d_stb, be_d_cyc, be_d_last;
    logic [31:0] be_d_dat;
    logic [3:0]  be_d_sel;
    logic [1:0]  be_d_tgc;

    logic        np1_s_ack, np1_s_stall, np1_d_stb, np1_d_cyc, np1_d_last;
    logic [7:0]  np1_d_dat;
    logic [0:0]  np1_d_sel;
    logic [1:0]  np1_d_tgc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) dut (
        .clk_i(clk), .rst_i(rst), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(le_s_ack),
        .s_stall_o(le_s_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc), .s_last_i(s_last),
        .d_stb_o(le_d_stb), .d_cyc_o(le_d_cyc), .d_ack_i(d_ack), .d_dat_o(le_d_dat),
        .d_sel_o(le_d_sel), .d_tgc_o(le_d_tgc), .d_last_o(le_d_last));

    wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0)) dut_be (
        .clk_i(clk), .rst_i(rst), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(be_s_ack),
        .s_stall_o(be_s_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc), .s_last_i(s_last),
        .d_stb_o(be_d_stb), .d_cyc_o(be_d_cyc), .d_ack_i(d_ack), .d_dat_o(be_d_dat),
        .d_sel_o(be_d_sel), .d_tgc_o(be_d_tgc), .d_last_o(be_d_last));

    wish_pack_flex #(.DATA_WIDTH(8), .NUM_PACK(1), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) dut_np1 (
        .clk_i(clk), .rst_i(rst), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(np1_s_ack),
        .s_stall_o(np1_s_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc), .s_last_i(s_last),
        .d_stb_o(np1_d_stb), .d_cyc_o(np1_d_cyc), .d_ack_i(d_ack), .d_dat_o(np1_d_dat),
        .d_sel_o(np1_d_sel), .d_tgc_o(np1_d_tgc), .d_last_o(np1_d_last));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's source/destination inputs and lets combinational outputs settle.
    task automatic applyStimulus(input logic stb, input logic cyc, input logic [7:0] dat,
                                 input logic [1:0] tgc, input logic last, input logic ack);
        s_stb  = stb;
        s_cyc  = cyc;
        s_dat  = dat;
        s_tgc  = tgc;
        s_last = last;
        d_ack  = ack;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'hEE, 2'b11, 1'b1, 1'b1);
        checkOutput("rst_s_ack", le_s_ack, 0);
        checkOutput("rst_s_stall", le_s_stall, 0);
        stepClock();
        checkOutput("rst_d_stb", le_d_stb, 0);
        checkOutput("rst_d_cyc", le_d_cyc, 0);
        checkOutput("rst_d_dat", le_d_dat, 0);
        checkOutput("rst_d_sel", le_d_sel, 0);
        checkOutput("rst_d_tgc", le_d_tgc, 0);
        checkOutput("rst_d_last", le_d_last, 0);
        checkOutput("rst_s_ack_held", le_s_ack, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] packOf(input int first);
        return {8'(first + 3), 8'(first + 2), 8'(first + 1), 8'(first)};
    endfunction

    initial begin
        int cur;
        logic stb_now;
        logic took;
        logic exp_stall;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        stepClock();
        resetDut();

        // Full pack, ack always high: both endian variants.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 8'((i + 1) * 17), 2'b00, 1'b0, 1'b1);
            checkOutput("t1_s_ack", le_s_ack, 1);
            stepClock();
            if (i < 3) checkOutput("t1_stb_early", le_d_stb, 0);
        end
        checkOutput("t1_d_stb", le_d_stb, 1);
        checkOutput("t1_d_cyc", le_d_cyc, 1);
        checkOutput("t1_d_dat", le_d_dat, 32'h44332211);
        checkOutput("t1_d_sel", le_d_sel, 4'hF);
        checkOutput("t1_d_last", le_d_last, 0);
        checkOutput("t1_be_d_dat", be_d_dat, 32'h11223344);
        checkOutput("t1_be_d_sel", be_d_sel, 4'hF);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        stepClock();
        checkOutput("t1_idle_stb", le_d_stb, 0);
        checkOutput("t1_idle_dat", le_d_dat, 0);

        // Short frame flushed by s_last with tag OR.
        applyStimulus(1'b1, 1'b1, 8'hAA, 2'b01, 1'b0, 1'b1);
        stepClock();
        checkOutput("t2_stb_early", le_d_stb, 0);
        applyStimulus(1'b1, 1'b1, 8'hBB, 2'b10, 1'b1, 1'b1);
        stepClock();
        checkOutput("t2_d_stb", le_d_stb, 1);
        checkOutput("t2_d_dat", le_d_dat, 32'h0000BBAA);
        checkOutput("t2_d_sel", le_d_sel, 4'h3);
        checkOutput("t2_d_tgc", le_d_tgc, 2'b11);
        checkOutput("t2_d_last", le_d_last, 1);
        checkOutput("t2_be_d_dat", be_d_dat, 32'hAABB0000);
        checkOutput("t2_be_d_sel", be_d_sel, 4'hC);
        checkOutput("t2_be_d_last", be_d_last, 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        stepClock();

        // Destination stalled for 12 cycles while streaming 0x01..0x0C.
        cur = 1;
        for (int c = 1; c <= 16; c++) begin
            stb_now   = (cur <= 12);
            exp_stall = (c >= 9 && c <= 12);
            applyStimulus(stb_now, 1'b1, 8'(cur), 2'b00, 1'b0, c >= 13);
            checkOutput($sformatf("t3_stall_c%0d", c), le_s_stall, exp_stall);
            checkOutput($sformatf("t3_ack_c%0d", c), le_s_ack, stb_now & !exp_stall);
            took = le_s_ack;
            stepClock();
            if (took) cur++;
            if (c <= 3 || c == 14 || c == 15) begin
                checkOutput($sformatf("t3_stb_c%0d", c), le_d_stb, 0);
            end else if (c <= 12) begin
                checkOutput($sformatf("t3_stb_c%0d", c), le_d_stb, 1);
                checkOutput($sformatf("t3_dat_c%0d", c), le_d_dat, 32'h04030201);
            end else if (c == 13) begin
                checkOutput("t3_stb_c13", le_d_stb, 1);
                checkOutput("t3_dat_c13", le_d_dat, 32'h08070605);
            end else begin
                checkOutput("t3_stb_c16", le_d_stb, 1);
                checkOutput("t3_dat_c16", le_d_dat, 32'h0C0B0A09);
            end
        end
        checkOutput("t3_words_taken", 64'(cur), 13);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        stepClock();
        checkOutput("t3_drain_stb", le_d_stb, 0);

        // Continuous stream with immediate ack; NUM_PACK=1 holds its strobe back-to-back.
        resetDut();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h30 + i), 2'b00, 1'b0, 1'b1);
            checkOutput($sformatf("t4_stall_%0d", i), le_s_stall, 0);
            stepClock();
            if ((i % 4) == 3) begin
                checkOutput($sformatf("t4_stb_%0d", i), le_d_stb, 1);
                checkOutput($sformatf("t4_dat_%0d", i), le_d_dat, packOf(8'h30 + i - 3));
            end else begin
                checkOutput($sformatf("t4_stb_%0d", i), le_d_stb, 0);
            end
            checkOutput($sformatf("t4_np1_stb_%0d", i), np1_d_stb, 1);
            checkOutput($sformatf("t4_np1_dat_%0d", i), np1_d_dat, 8'(8'h30 + i));
            checkOutput($sformatf("t4_np1_sel_%0d", i), np1_d_sel, 1);
        end
        checkOutput("t4_np1_cyc", np1_d_cyc, 1);
        checkOutput("t4_np1_last", np1_d_last, 0);
        checkOutput("t4_np1_tgc", np1_d_tgc, 0);
        checkOutput("t4_np1_stall", np1_s_stall, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        stepClock();

        // Reset after two words, a cyc-less strobe, then a full pack ended by s_last.
        applyStimulus(1'b1, 1'b1, 8'hE1, 2'b01, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b1, 1'b1, 8'hE2, 2'b01, 1'b0, 1'b1);
        stepClock();
        resetDut();
        applyStimulus(1'b1, 1'b0, 8'h99, 2'b11, 1'b1, 1'b1);
        checkOutput("t5_nocyc_ack", le_s_ack, 0);
        stepClock();
        checkOutput("t5_nocyc_stb", le_d_stb, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'hF1 + i), (i == 3) ? 2'b10 : 2'b00, i == 3, 1'b1);
            stepClock();
            if (i < 3) checkOutput($sformatf("t5_stb_early_%0d", i), le_d_stb, 0);
        end
        checkOutput("t5_d_stb", le_d_stb, 1);
        checkOutput("t5_d_dat", le_d_dat, 32'hF4F3F2F1);
        checkOutput("t5_d_sel", le_d_sel, 4'hF);
        checkOutput("t5_d_tgc", le_d_tgc, 2'b10);
        checkOutput("t5_d_last", le_d_last, 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        stepClock();
        checkOutput("t5_drain_stb", le_d_stb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
